// File: rtl/mem_pkg.sv
// Shared definitions for the parameterised data memory: access sizes, FSM states,
// latency bounds and the alignment helper used when DMEM_ALIGN_CHECK_EN is defined.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational little-endian byte-lane merge of store data into the addressed word.
// Low address bits below the access size are ignored here; alignment errors are decided by the caller.
module mem_lane_merge
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        i_size,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_old_word,
    output logic [DATA_W-1:0] o_merged
);

    localparam int NB = DATA_W / 8;

    always_comb begin
        o_merged = i_old_word;
        for (int i = 0; i < NB; i++) begin
            case (i_size)
                SZ_BYTE: if (2'(i) == i_addr_lo) o_merged[8*i +: 8] = i_wdata[7:0];
                // Half-word occupies the lane pair selected by addr[1]
                SZ_HALF: if ((i >> 1) == int'(i_addr_lo[1])) o_merged[8*i +: 8] = i_wdata[8*(i%2) +: 8];
                SZ_WORD: o_merged[8*i +: 8] = i_wdata[8*i +: 8];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/param_data_mem.sv
// Single-port data memory with clear-on-reset, fixed response latency and byte/half/word stores.
// Optional macro DMEM_ALIGN_CHECK_EN turns misaligned half/word accesses into error responses.
module param_data_mem
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    output logic              wr_ack,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 2;
    localparam int LAT   = (LATENCY < LAT_MIN) ? LAT_MIN : ((LATENCY > LAT_MAX) ? LAT_MAX : LATENCY);

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_clr_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_rd;
    logic              r_is_wr;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata_p1;

    logic              w_accept;
    logic              w_active;
    logic              w_err;
    logic              w_we;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_merged;
    logic              w_unused_hi;

    assign w_idx       = addr[IDX_W+1:2];
    assign w_unused_hi = ^addr[31:IDX_W+2];
    assign w_accept    = req_valid & req_ready;
    assign w_active    = MemRead | MemWrite;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = w_active & ((MemRead & MemWrite) | (size == SZ_RSVD) | misaligned(size, addr[1:0]));
`else
    assign w_err = w_active & ((MemRead & MemWrite) | (size == SZ_RSVD));
`endif

    assign w_we = w_accept & MemWrite & ~MemRead & ~w_err;

    mem_lane_merge #(.DATA_W(DATA_W)) u_merge (
        .i_size     (size),
        .i_addr_lo  (addr[1:0]),
        .i_wdata    (write_data),
        .i_old_word (r_mem[w_idx]),
        .o_merged   (w_merged)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (w_accept) w_state_nxt = (LAT > 1) ? ST_WAIT : ST_RESP;
            ST_WAIT:  if (r_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_CLEAR;
        else     r_state <= w_state_nxt;
    end

    // Accept stage: capture response kind and WAIT countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= '0;
            r_cnt     <= '0;
            r_is_rd   <= 1'b0;
            r_is_wr   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
            if (w_accept) begin
                r_cnt   <= CNT_W'((LAT > 1) ? LAT - 2 : 0);
                r_is_rd <= MemRead & ~MemWrite & ~w_err;
                r_is_wr <= MemWrite & ~MemRead & ~w_err;
                r_err   <= w_err;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) r_mem[r_clr_idx] <= '0;
        else if (w_we)           r_mem[w_idx]     <= w_merged;
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_rdata_p1 <= r_mem[w_idx];
    end

    // Response stage: pulses only in RESP and forced low while reset is asserted
    assign req_ready = ~rst & (r_state == ST_IDLE);
    assign busy      = rst | (r_state != ST_IDLE);
    assign rd_valid  = ~rst & (r_state == ST_RESP) & r_is_rd;
    assign wr_ack    = ~rst & (r_state == ST_RESP) & r_is_wr;
    assign err       = ~rst & (r_state == ST_RESP) & r_err;
    assign read_data = rd_valid ? r_rdata_p1 : '0;

endmodule

// File: tb/tb_param_data_mem.sv
// Bench for param_data_mem (DEPTH=256, LATENCY=3): directed vector table, reset corner
// sequences, and random traffic checked against a byte-addressed memory model.
module tb_param_data_mem;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 3;
    localparam int NBYTES  = 4 * DEPTH;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       addr;
    logic [1:0]        size;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              rd_valid;
    logic              wr_ack;
    logic              err;
    logic              busy;

    param_data_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .size       (size),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .wr_ack     (wr_ack),
        .err        (err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] mb [NBYTES];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic        rv;
        logic        wa;
        logic        er;
        logic [31:0] rdat;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int b;
        b = int'(a % NBYTES) & ~3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    // Reference behaviour: decide the response and apply any store to the byte array
    task automatic model_xact(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                              input logic [31:0] wd, output logic rv, output logic wa, output logic er,
                              output logic [31:0] rdat);
        int  ba;
        logic mis;
        ba   = int'(a % NBYTES);
        mis  = ALIGN && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0));
        er   = (rd || wr) && ((rd && wr) || sz == 2'd3 || mis);
        rv   = rd && !wr && !er;
        wa   = wr && !rd && !er;
        rdat = rv ? model_word(a) : 32'd0;
        if (wa) begin
            if (sz == 2'd0) begin
                mb[ba] = wd[7:0];
            end else if (sz == 2'd1) begin
                mb[ba & ~1]       = wd[7:0];
                mb[(ba & ~1) + 1] = wd[15:8];
            end else begin
                for (int k = 0; k < 4; k++) mb[(ba & ~3) + k] = wd[8*k +: 8];
            end
        end
    endtask

    task automatic xact(input string name, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd, input logic rv, input logic wa,
                        input logic er, input logic [31:0] rdat);
        int   n;
        logic early;
        n = 0;
        while (req_ready !== 1'b1 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, ":ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; MemRead = rd; MemWrite = wr; addr = a; size = sz; write_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        early = 1'b0;
        for (int k = 1; k < LATENCY; k++) begin
            early |= rd_valid | wr_ack | err | req_ready | ~busy;
            @(posedge clk); #1;
        end
        check({name, ":early"}, 32'(early), 32'd0);
        check({name, ":pulses"}, 32'({rd_valid, wr_ack, err}), 32'({rv, wa, er}));
        check({name, ":rdata"}, read_data, rdat);
        @(posedge clk); #1;
        check({name, ":ready_after"}, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_clear(input string name, output logic seen);
        int n;
        n    = 0;
        seen = 1'b0;
        while (busy === 1'b1 && n < 1000) begin
            seen |= rd_valid | wr_ack | err | req_ready;
            @(posedge clk); #1;
            n++;
        end
        check({name, ":clear_cycles"}, 32'(n), 32'(DEPTH));
        check({name, ":ready"}, 32'(req_ready), 32'd1);
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    endtask

    initial begin
        logic        seen;
        logic        rv, wa, er;
        logic [31:0] rdat, a, wd;
        logic        rd, wr;
        logic [1:0]  sz;
        int          r;

        rst = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        addr = '0; size = '0; write_data = '0;

        tbl[0]  = '{1'b0, 1'b1, 32'h8,   2'd2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h8,   2'd2, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'h4,   2'd2, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 32'h6,   2'd0, 32'h000000AA, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h4,   2'd1, 32'h0000BBCC, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h4,   2'd2, 32'h0,        1'b1, 1'b0, 1'b0, 32'h11AABBCC};
        tbl[6]  = '{1'b1, 1'b1, 32'h0,   2'd2, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,   2'd2, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'h400, 2'd2, 32'h5,        1'b0, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,   2'd2, 32'h0,        1'b1, 1'b0, 1'b0, 32'h5};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   2'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   2'd3, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 32'h404, 2'd2, 32'h0,        1'b1, 1'b0, 1'b0, 32'h11AABBCC};
        tbl[13] = '{1'b0, 1'b1, 32'hA,   2'd1, 32'h00001234, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b1, 32'h2,   2'd2, 32'hFFFFFFFF, 1'b0, !ALIGN, ALIGN, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 32'h0,   2'd2, 32'h0,        1'b1, 1'b0, 1'b0, ALIGN ? 32'h5 : 32'hFFFFFFFF};

        repeat (3) @(posedge clk);
        #1;
        check("rst:req_ready", 32'(req_ready), 32'd0);
        check("rst:busy", 32'(busy), 32'd1);
        check("rst:pulses", 32'({rd_valid, wr_ack, err}), 32'd0);
        check("rst:read_data", read_data, 32'd0);
        rst = 1'b0;
        wait_clear("init", seen);
        check("init:no_pulse", 32'(seen), 32'd0);

        a = $urandom;
        xact("read_after_clear", 1'b1, 1'b0, a, 2'd2, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 16; i++) begin
            model_xact(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, rv, wa, er, rdat);
            xact($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd,
                 tbl[i].rv, tbl[i].wa, tbl[i].er, tbl[i].rdat);
        end
        xact("half_lanes", 1'b1, 1'b0, 32'h8, 2'd2, 32'd0, 1'b1, 1'b0, 1'b0, 32'h1234BEEF);

        // Reset while an accepted write sits in WAIT
        while (req_ready !== 1'b1) begin @(posedge clk); #1; end
        req_valid = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; addr = 32'h10; size = 2'd2; write_data = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0; MemWrite = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst:busy", 32'(busy), 32'd1);
        check("midrst:ready", 32'(req_ready), 32'd0);
        check("midrst:pulses", 32'({rd_valid, wr_ack, err}), 32'd0);
        rst = 1'b0;
        wait_clear("midrst", seen);
        check("midrst:no_ack", 32'(seen), 32'd0);
        xact("midrst_rd10", 1'b1, 1'b0, 32'h10, 2'd2, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        xact("midrst_rd08", 1'b1, 1'b0, 32'h8,  2'd2, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 250; i++) begin
            r  = int'($urandom_range(0, 9));
            rd = (r <= 3) || (r == 8);
            wr = (r >= 4 && r <= 8);
            sz = (r == 9) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            wd = $urandom;
            model_xact(rd, wr, a, sz, wd, rv, wa, er, rdat);
            xact($sformatf("rand%0d", i), rd, wr, a, sz, wd, rv, wa, er, rdat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_data_mem.md
PARAM_DATA_MEM -- requirements
Module: param_data_mem

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 Parameter DEPTH, default 256, number of words (power of 2, >=4).
REQ-003 Parameter LATENCY, default 1, request-accept to response cycles (1..4).
REQ-004 clk  in  1  the only clock; every register updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 MemRead  in  1  request is a read.
REQ-009 MemWrite  in  1  request is a write.
REQ-010 addr  in  32  byte address.
REQ-011 size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-012 write_data  in  DATA_W  store data, right-aligned for byte and half.
REQ-013 read_data  out  DATA_W  full aligned word; valid only while rd_valid=1.
REQ-014 rd_valid  out  1  one-cycle read response pulse.
REQ-015 wr_ack  out  1  one-cycle write completion pulse.
REQ-016 err  out  1  one-cycle error pulse, coincident with that request's response.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 States: CLEAR, IDLE, WAIT, RESP. req_ready=1 only in IDLE.
REQ-019 CLEAR zeroes one word per cycle (index 0..DEPTH-1) and moves to IDLE after index DEPTH-1; clearing takes DEPTH cycles.
REQ-020 Accept = req_valid & req_ready; IDLE->WAIT on accept (LATENCY>1) or IDLE->RESP (LATENCY=1); WAIT counts down to RESP; RESP->IDLE unconditionally.
REQ-021 Response pulse falls in the cycle exactly LATENCY cycles after the accept cycle; next accept is no earlier than the cycle after RESP.
REQ-022 Word index = addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-023 Read: word sampled at accept, held, driven on read_data with rd_valid=1 in RESP; read_data=0 otherwise.
REQ-024 Write: committed at the accept edge, little-endian lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all lanes; other lanes unchanged; wr_ack=1 in RESP.
REQ-025 MemRead=MemWrite=1, or size=11: no memory change, err=1 and rd_valid=wr_ack=0 in RESP.
REQ-026 Accept with MemRead=MemWrite=0: no-op, RESP with all pulses 0.
REQ-027 A read directly after a write to the same word returns the new data.

Reset
REQ-028 rst=1 at any edge, mid-operation included: in-flight request dropped without response, state->CLEAR, clear index->0.
REQ-029 Output values during and after reset: req_ready=0, rd_valid=0, wr_ack=0, err=0, read_data=0, busy=1.
REQ-030 Stores held in memory before reset are lost; every word reads 0 once CLEAR completes.

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned: no write, err=1 in RESP, no rd_valid/wr_ack.
REQ-032 Macro absent: low address bits are ignored for alignment (half uses addr[1] only, word ignores addr[1:0]); err is raised only per REQ-025.

Structure
REQ-033 Shared package mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding, LATENCY bounds.
REQ-034 Sub-module mem_lane_merge: combinational byte-lane write-mask/data merge from size, addr[1:0], write_data.

Verification
REQ-035 Release rst, DEPTH=256 -> busy=1 for 256 cycles, then req_ready=1; read any addr -> read_data=0.
REQ-036 LATENCY=3: word write 0xDEADBEEF to addr 8, read addr 8 -> wr_ack 3 cycles after write accept; rd_valid with 0xDEADBEEF 3 cycles after read accept.
REQ-037 Word 0x11223344 at addr 4, byte write 0xAA at addr 6, half write 0xBBCC at addr 4 -> read addr 4 returns 0x11AABBCC.
REQ-038 MemRead=MemWrite=1 at addr 0 -> err pulse, no rd_valid/wr_ack, word 0 unchanged; with DMEM_ALIGN_CHECK_EN, word write at addr 2 -> err, memory unchanged.
REQ-039 Write 0x5 to addr 0x400 (DEPTH=256) -> read addr 0 returns 0x5 (wrap).
REQ-040 rst during WAIT of a write that was already accepted -> no wr_ack, CLEAR restarts, addr reads 0 afterwards.
